// File: rtl/pipe_stage_reg_param_if.sv
// Bundle of upstream inputs and last-stage outputs for pipe_stage_reg_param.
// The upstream stage is the master; the pipeline register is the slave.
interface pipe_stage_reg_param_if #(
  parameter int CTRL_W = 4,
  parameter int DATA_W = 101,
  parameter int DEPTH  = 1
);
  localparam int CW = $clog2(DEPTH + 1);

  logic              stall_i;
  logic              flush_i;
  logic              valid_i;
  logic [CTRL_W-1:0] ctrl_i;
  logic [DATA_W-1:0] data_i;
  logic              valid_o;
  logic [CTRL_W-1:0] ctrl_o;
  logic [DATA_W-1:0] data_o;
  logic [CW-1:0]     occupancy_o;

  modport master (
    output stall_i, flush_i, valid_i, ctrl_i, data_i,
    input  valid_o, ctrl_o, data_o, occupancy_o
  );

  modport slave (
    input  stall_i, flush_i, valid_i, ctrl_i, data_i,
    output valid_o, ctrl_o, data_o, occupancy_o
  );
endinterface

// File: rtl/pipe_stage_reg_param.sv
// Parametrised inter-stage pipeline register: DEPTH stages of valid/ctrl/data
// with stall (hold), flush (bubble insertion) and a registered occupancy count.
module pipe_stage_reg_param #(
  parameter int CTRL_W     = 4,
  parameter int DATA_W     = 101,
  parameter int DEPTH      = 1,
  parameter int FLUSH_DATA = 0
) (
  input logic                    clk,
  input logic                    rst_n,
  pipe_stage_reg_param_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic              valid;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } stage_t;

  localparam stage_t STAGE_ZERO = '0;

  if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
    $error("pipe_stage_reg_param: DEPTH must be within 1..8");
  end
  if (CTRL_W < 1 || DATA_W < 1) begin : g_bad_width
    $error("pipe_stage_reg_param: CTRL_W and DATA_W must be at least 1");
  end

  stage_t           capture;
  stage_t           chain [DEPTH];
  logic [DEPTH-1:0] valid_vec;
  logic [CW-1:0]    occ_reg;
  logic [CW-1:0]    occ_next;
  logic             last_valid;

  // Control of a bubble is zeroed at capture so ctrl_o can stay a pure register.
  always_comb begin
    capture       = STAGE_ZERO;
    capture.valid = bus.valid_i;
    capture.ctrl  = bus.valid_i ? bus.ctrl_i : '0;
    capture.data  = (FLUSH_DATA != 0 && !bus.valid_i) ? '0 : bus.data_i;
  end

  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_stage
    stage_t stage_reg;
    stage_t stage_in;

    if (gi == 0) begin : g_head
      assign stage_in = capture;
    end else begin : g_body
      assign stage_in = chain[gi-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stage_reg <= STAGE_ZERO;
      end else if (bus.flush_i) begin
        stage_reg.valid <= 1'b0;
        stage_reg.ctrl  <= '0;
        if (FLUSH_DATA != 0) begin
          stage_reg.data <= '0;
        end
      end else if (!bus.stall_i) begin
        stage_reg <= stage_in;
      end
    end

    assign chain[gi]     = stage_reg;
    assign valid_vec[gi] = stage_reg.valid;
  end

  assign last_valid = valid_vec[DEPTH-1];

  // Modular CW-bit arithmetic is exact here because the true result is <= DEPTH.
  always_comb begin
    occ_next = occ_reg;
    if (bus.flush_i) begin
      occ_next = '0;
    end else if (!bus.stall_i) begin
      occ_next = occ_reg + CW'(bus.valid_i) - CW'(last_valid);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_reg <= '0;
    end else begin
      occ_reg <= occ_next;
    end
  end

  assign bus.valid_o     = chain[DEPTH-1].valid;
  assign bus.ctrl_o      = chain[DEPTH-1].ctrl;
  assign bus.data_o      = chain[DEPTH-1].data;
  assign bus.occupancy_o = occ_reg;

  occ_matches_popcount: assert property (@(posedge clk) disable iff (!rst_n)
    occ_reg == CW'($countones(valid_vec)));

  occ_within_depth: assert property (@(posedge clk) disable iff (!rst_n)
    int'(occ_reg) <= DEPTH);
endmodule

// File: tb/tb_pipe_stage_reg_param.sv
// Bench for pipe_stage_reg_param: three instances (DEPTH 1, DEPTH 3, DEPTH 3 with
// FLUSH_DATA) share one stimulus stream and are checked against a queue model.
module tb_pipe_stage_reg_param;
  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        vin   = 1'b0;
  logic [3:0]  cin   = 4'h0;
  logic [31:0] din   = 32'h0;

  always #5 clk = ~clk;

  pipe_stage_reg_param_if #(.CTRL_W(4), .DATA_W(32), .DEPTH(1)) if1  ();
  pipe_stage_reg_param_if #(.CTRL_W(4), .DATA_W(32), .DEPTH(3)) if3a ();
  pipe_stage_reg_param_if #(.CTRL_W(4), .DATA_W(32), .DEPTH(3)) if3b ();

  assign if1.stall_i  = stall;
  assign if1.flush_i  = flush;
  assign if1.valid_i  = vin;
  assign if1.ctrl_i   = cin;
  assign if1.data_i   = din;
  assign if3a.stall_i = stall;
  assign if3a.flush_i = flush;
  assign if3a.valid_i = vin;
  assign if3a.ctrl_i  = cin;
  assign if3a.data_i  = din;
  assign if3b.stall_i = stall;
  assign if3b.flush_i = flush;
  assign if3b.valid_i = vin;
  assign if3b.ctrl_i  = cin;
  assign if3b.data_i  = din;

  pipe_stage_reg_param #(.CTRL_W(4), .DATA_W(32), .DEPTH(1), .FLUSH_DATA(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1));
  pipe_stage_reg_param #(.CTRL_W(4), .DATA_W(32), .DEPTH(3), .FLUSH_DATA(0)) dut3a (
    .clk(clk), .rst_n(rst_n), .bus(if3a));
  pipe_stage_reg_param #(.CTRL_W(4), .DATA_W(32), .DEPTH(3), .FLUSH_DATA(1)) dut3b (
    .clk(clk), .rst_n(rst_n), .bus(if3b));

  logic        out_valid [3];
  logic [3:0]  out_ctrl  [3];
  logic [31:0] out_data  [3];
  logic [3:0]  out_occ   [3];

  assign out_valid[0] = if1.valid_o;
  assign out_ctrl[0]  = if1.ctrl_o;
  assign out_data[0]  = if1.data_o;
  assign out_occ[0]   = 4'(if1.occupancy_o);
  assign out_valid[1] = if3a.valid_o;
  assign out_ctrl[1]  = if3a.ctrl_o;
  assign out_data[1]  = if3a.data_o;
  assign out_occ[1]   = 4'(if3a.occupancy_o);
  assign out_valid[2] = if3b.valid_o;
  assign out_ctrl[2]  = if3b.ctrl_o;
  assign out_data[2]  = if3b.data_o;
  assign out_occ[2]   = 4'(if3b.occupancy_o);

  typedef struct packed {
    logic        v;
    logic [3:0]  c;
    logic [31:0] d;
  } ent_t;

  // Per instance, a queue of stage contents: front is stage 0, back is the output stage.
  ent_t mq [3][$];
  int   dep [3] = '{1, 3, 3};
  bit   fd  [3] = '{1'b0, 1'b0, 1'b1};
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic ent_t model_out(int i);
    return mq[i][dep[i]-1];
  endfunction

  function automatic logic [3:0] model_occ(int i);
    logic [3:0] n = 4'h0;
    for (int k = 0; k < mq[i].size(); k++) begin
      if (mq[i][k].v) n = n + 4'h1;
    end
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mq[i].delete();
      for (int k = 0; k < dep[i]; k++) mq[i].push_back('0);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      if (flush) begin
        for (int k = 0; k < mq[i].size(); k++) begin
          ent_t e;
          e   = mq[i][k];
          e.v = 1'b0;
          e.c = 4'h0;
          if (fd[i]) e.d = 32'h0;
          mq[i][k] = e;
        end
      end else if (!stall) begin
        ent_t e;
        ent_t dropped;
        e.v = vin;
        e.c = vin ? cin : 4'h0;
        e.d = (fd[i] && !vin) ? 32'h0 : din;
        mq[i].push_front(e);
        dropped = mq[i].pop_back();
      end
    end
  endtask

  // Drive one cycle of stimulus, advance the model, and return 1 time unit after the edge.
  task automatic step(input logic v, input logic [3:0] c, input logic [31:0] d,
                      input logic st, input logic fl);
    vin   = v;
    cin   = c;
    din   = d;
    stall = st;
    flush = fl;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    #12;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (out_valid[i] !== 1'b0 || out_ctrl[i] !== 4'h0 || out_data[i] !== 32'h0 || out_occ[i] !== 4'h0) begin
        n_err++;
        $display("FAIL reset[%0d]: got v=%b c=%h d=%h occ=%0d, want all zero",
                 i, out_valid[i], out_ctrl[i], out_data[i], out_occ[i]);
      end
    end
    rst_n = 1'b1;
    step(1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
    $display("reset: released, occ = %0d/%0d/%0d", out_occ[0], out_occ[1], out_occ[2]);
  endtask

  task automatic test_single();
    step(1'b1, 4'hB, 32'h1234_5678, 1'b0, 1'b0);
    n_cmp++;
    if (out_valid[0] !== 1'b1 || out_ctrl[0] !== 4'hB || out_data[0] !== 32'h1234_5678 || out_occ[0] !== 4'h1) begin
      n_err++;
      $display("FAIL single: got v=%b c=%h d=%h occ=%0d, want v=1 c=b d=12345678 occ=1",
               out_valid[0], out_ctrl[0], out_data[0], out_occ[0]);
    end
    $display("single: v=%b c=%h d=%h occ=%0d", out_valid[0], out_ctrl[0], out_data[0], out_occ[0]);
  endtask

  task automatic test_fill_drain();
    logic [3:0]  exp_occ   [8] = '{4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd2, 4'd1, 4'd0};
    logic        exp_valid [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] exp_data  [8] = '{32'd0, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd0};
    step(1'b0, 4'h0, 32'h0, 1'b0, 1'b1);
    n_cmp++;
    if (out_occ[1] !== 4'h0 || out_valid[1] !== 1'b0) begin
      n_err++;
      $display("FAIL fill_clear: got v=%b occ=%0d, want v=0 occ=0", out_valid[1], out_occ[1]);
    end
    for (int k = 1; k <= 8; k++) begin
      if (k <= 5) step(1'b1, 4'(k), 32'(k), 1'b0, 1'b0);
      else        step(1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
      n_cmp++;
      if (out_occ[1] !== exp_occ[k-1] || out_valid[1] !== exp_valid[k-1] ||
          (exp_valid[k-1] && (out_data[1] !== exp_data[k-1] || out_ctrl[1] !== exp_data[k-1][3:0])) ||
          (!exp_valid[k-1] && out_ctrl[1] !== 4'h0)) begin
        n_err++;
        $display("FAIL fill_drain edge %0d: got v=%b c=%h d=%h occ=%0d, want v=%b d=%h occ=%0d",
                 k, out_valid[1], out_ctrl[1], out_data[1], out_occ[1],
                 exp_valid[k-1], exp_data[k-1], exp_occ[k-1]);
      end
      $display("fill_drain edge %0d: v=%b d=%h occ=%0d", k, out_valid[1], out_data[1], out_occ[1]);
    end
  endtask

  task automatic test_stall();
    for (int k = 10; k <= 12; k++) step(1'b1, 4'(k), 32'(k), 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) step(1'b1, 4'hF, 32'd99, 1'b1, 1'b0);
      n_cmp++;
      if (out_valid[1] !== 1'b1 || out_data[1] !== 32'd10 || out_ctrl[1] !== 4'hA || out_occ[1] !== 4'd3) begin
        n_err++;
        $display("FAIL stall_hold %0d: got v=%b c=%h d=%0d occ=%0d, want v=1 c=a d=10 occ=3",
                 k, out_valid[1], out_ctrl[1], out_data[1], out_occ[1]);
      end
      $display("stall cycle %0d: d=%0d occ=%0d", k, out_data[1], out_occ[1]);
    end
    for (int k = 13; k <= 15; k++) begin
      step(1'b1, 4'(k), 32'(k), 1'b0, 1'b0);
      n_cmp++;
      if (out_valid[1] !== 1'b1 || out_data[1] !== 32'(k - 2) || out_occ[1] !== 4'd3) begin
        n_err++;
        $display("FAIL stall_resume %0d: got v=%b d=%0d occ=%0d, want v=1 d=%0d occ=3",
                 k, out_valid[1], out_data[1], out_occ[1], k - 2);
      end
      $display("resume issue %0d: d=%0d occ=%0d", k, out_data[1], out_occ[1]);
    end
  endtask

  task automatic test_flush();
    step(1'b1, 4'h7, 32'd77, 1'b1, 1'b1);
    n_cmp++;
    if (out_valid[1] !== 1'b0 || out_ctrl[1] !== 4'h0 || out_occ[1] !== 4'h0 || out_data[1] !== 32'd13) begin
      n_err++;
      $display("FAIL flush_keep: got v=%b c=%h d=%0d occ=%0d, want v=0 c=0 d=13 occ=0",
               out_valid[1], out_ctrl[1], out_data[1], out_occ[1]);
    end
    n_cmp++;
    if (out_valid[2] !== 1'b0 || out_ctrl[2] !== 4'h0 || out_occ[2] !== 4'h0 || out_data[2] !== 32'd0) begin
      n_err++;
      $display("FAIL flush_zero: got v=%b c=%h d=%0d occ=%0d, want all zero",
               out_valid[2], out_ctrl[2], out_data[2], out_occ[2]);
    end
    n_cmp++;
    if (out_valid[0] !== 1'b0 || out_data[0] !== 32'd15 || out_occ[0] !== 4'h0) begin
      n_err++;
      $display("FAIL flush_d1: got v=%b d=%0d occ=%0d, want v=0 d=15 occ=0",
               out_valid[0], out_data[0], out_occ[0]);
    end
    step(1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
    n_cmp++;
    if (out_valid[1] !== 1'b0 || out_ctrl[1] !== 4'h0 || out_data[1] !== 32'd15 || out_occ[1] !== 4'h0) begin
      n_err++;
      $display("FAIL flush_discard: got v=%b c=%h d=%0d occ=%0d, want v=0 c=0 d=15 occ=0",
               out_valid[1], out_ctrl[1], out_data[1], out_occ[1]);
    end
    $display("flush: d3a=%0d d3b=%0d occ=%0d", out_data[1], out_data[2], out_occ[1]);
  endtask

  task automatic test_bubble_x();
    for (int k = 0; k < 3; k++) step(1'b0, 4'hF, 32'hxxxx_xxxx, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (out_valid[i] !== 1'b0 || out_ctrl[i] !== 4'h0 || out_occ[i] !== 4'h0) begin
        n_err++;
        $display("FAIL bubble_x[%0d]: got v=%b c=%h occ=%0d, want v=0 c=0 occ=0",
                 i, out_valid[i], out_ctrl[i], out_occ[i]);
      end
    end
    n_cmp++;
    if (out_data[2] !== 32'h0) begin
      n_err++;
      $display("FAIL bubble_zero_data: got d=%h, want 0", out_data[2]);
    end
    $display("bubble_x: v=%b c=%h", out_valid[1], out_ctrl[1]);
  endtask

  task automatic test_reset_mid();
    for (int k = 1; k <= 3; k++) step(1'b1, 4'(k), 32'(100 + k), 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (out_valid[i] !== 1'b0 || out_ctrl[i] !== 4'h0 || out_data[i] !== 32'h0 || out_occ[i] !== 4'h0) begin
        n_err++;
        $display("FAIL reset_mid[%0d]: got v=%b c=%h d=%h occ=%0d, want all zero",
                 i, out_valid[i], out_ctrl[i], out_data[i], out_occ[i]);
      end
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 4'h3, 32'd200, 1'b0, 1'b0);
    n_cmp++;
    if (out_occ[0] !== 4'd1 || out_occ[1] !== 4'd1 || out_valid[0] !== 1'b1 ||
        out_data[0] !== 32'd200 || out_valid[1] !== 1'b0) begin
      n_err++;
      $display("FAIL reset_restart: got occ=%0d/%0d v1=%b d1=%0d v3=%b, want occ=1/1 v1=1 d1=200 v3=0",
               out_occ[0], out_occ[1], out_valid[0], out_data[0], out_valid[1]);
    end
    $display("reset_mid: restart occ=%0d/%0d", out_occ[0], out_occ[1]);
  endtask

  task automatic test_random();
    int start_err;
    start_err = n_err;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom), $urandom,
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 19) == 0));
      for (int i = 0; i < 3; i++) begin
        ent_t e;
        e = model_out(i);
        n_cmp++;
        if (out_valid[i] !== e.v || out_ctrl[i] !== e.c || out_data[i] !== e.d || out_occ[i] !== model_occ(i)) begin
          n_err++;
          $display("FAIL random[%0d] cyc %0d: got v=%b c=%h d=%h occ=%0d, want v=%b c=%h d=%h occ=%0d",
                   i, cyc, out_valid[i], out_ctrl[i], out_data[i], out_occ[i],
                   e.v, e.c, e.d, model_occ(i));
        end
      end
    end
    $display("random: 10000 cycles, %0d new mismatches", n_err - start_err);
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_stall();
    test_flush();
    test_bubble_x();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
